vedic_mult_pipe: RTL and testbench

Parametrised, pipelined NxN Vedic (Urdhva-Tiryagbhyam) multiplier. It is the successor of the team's combinational 2x2 Vedic cell. The block recursively composes 2x2 partial products into a WIDTH x WIDTH product, with one register stage per recursion level. Valid/ready handshakes on input and output let it sit in streaming datapaths (DSP/MAC front-ends) and absorb downstream backpressure.

---
 rtl/vedic_mult_pipe.sv | 92 +++++++++
 tb/tb_vedic_mult_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: pipelined WIDTHxWIDTH Urdhva-Tiryagbhyam multiplier with valid/ready; `VEDIC_SIGNED_EN adds two's complement operands
module vedic_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] s
);
  localparam int LEVELS = $clog2(WIDTH);
  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_chk
    $error("vedic_mult_pipe: WIDTH must be a power of two >= 2");
  end
  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic c;
    c = x[1] & y[0] & x[0] & y[1];
    return {x[1] & y[1] & c, (x[1] & y[1]) ^ c, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
  endfunction
  logic               en;
  logic               cv;
  logic [WIDTH-1:0]   ca, cb;
  logic [LEVELS-1:0]  vr;
  logic [LEVELS:0]    vc;
  logic [2*WIDTH-1:0] prod;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign vc       = {vr, cv};
  always_ff @(posedge clk)
    if (rst) vr <= '0;
    else if (en) vr <= vc[LEVELS-1:0];
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lv
    localparam int N = 2 ** k;
    localparam int M = WIDTH / N;
    typedef logic [2*N-1:0] pt;
    pt p  [M*M];
    pt nx [M*M];
    for (genvar i = 0; i < M; i++) begin : g_i
      for (genvar j = 0; j < M; j++) begin : g_j
        if (k == 1) begin : g_cell
          assign nx[i*M+j] = vedic2(ca[2*i+:2], cb[2*j+:2]);
        end else begin : g_comb
          localparam int C = 2 * M;
          pt mid;
          assign mid = pt'(g_lv[k-1].p[2*i*C+2*j+1]) + pt'(g_lv[k-1].p[(2*i+1)*C+2*j]);
          assign nx[i*M+j] = pt'({g_lv[k-1].p[(2*i+1)*C+2*j+1], g_lv[k-1].p[2*i*C+2*j]})
                           + (mid << (N / 2));
        end
      end
    end
    always_ff @(posedge clk)
      if (rst) for (int x = 0; x < M*M; x++) p[x] <= '0;
      else if (en && vc[k-1]) p <= nx;
  end
  assign prod = g_lv[LEVELS].p[0];
`ifdef VEDIC_SIGNED_EN
  logic [LEVELS:0]    sg;
  logic               ov;
  logic [2*WIDTH-1:0] s_r;
  always_ff @(posedge clk)
    if (rst) begin
      cv  <= 1'b0;
      ca  <= '0;
      cb  <= '0;
      sg  <= '0;
      ov  <= 1'b0;
      s_r <= '0;
    end else if (en) begin
      cv <= in_valid;
      ov <= vc[LEVELS];
      if (in_valid) begin
        ca    <= a[WIDTH-1] ? -a : a;
        cb    <= b[WIDTH-1] ? -b : b;
        sg[0] <= a[WIDTH-1] ^ b[WIDTH-1];
      end
      for (int k = 1; k <= LEVELS; k++) if (vc[k-1]) sg[k] <= sg[k-1];
      if (vc[LEVELS]) s_r <= sg[LEVELS] ? -prod : prod;
    end
  assign out_valid = ov;
  assign s         = s_r;
`else
  assign cv        = in_valid;
  assign ca        = a;
  assign cb        = b;
  assign out_valid = vc[LEVELS];
  assign s         = prod;
`endif
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb_vedic_mult_pipe: directed table, backpressure, reset and streaming checks for vedic_mult_pipe
module tb_vedic_mult_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
`ifdef VEDIC_SIGNED_EN
  localparam int LAT8 = 5;
`else
  localparam int LAT8 = 3;
`endif
  logic iv8, ir8, ov8, or8;
  logic [7:0] a8, b8;
  logic [15:0] s8;
  logic iv4, ir4, ov4, or4;
  logic [3:0] a4, b4;
  logic [7:0] s4;
  logic iv16, ir16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] s16;
  vedic_mult_pipe #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
                                   .out_valid(ov8), .out_ready(or8), .s(s8));
  vedic_mult_pipe #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
                                   .out_valid(ov4), .out_ready(or4), .s(s4));
  vedic_mult_pipe #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
                                     .out_valid(ov16), .out_ready(or16), .s(s16));
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] su;
    logic [15:0] ss;
  } vec_t;
  vec_t tbl [12];
  logic [7:0]  q4 [$];
  logic [31:0] q16 [$];
  logic [15:0] bp_exp [3];
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  function automatic logic [7:0] m4(input logic [3:0] x, input logic [3:0] y);
`ifdef VEDIC_SIGNED_EN
    logic signed [7:0] sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
`else
    logic [7:0] ux, uy;
    ux = x;
    uy = y;
    return ux * uy;
`endif
  endfunction
  function automatic logic [31:0] m16(input logic [15:0] x, input logic [15:0] y);
`ifdef VEDIC_SIGNED_EN
    logic signed [31:0] sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
`else
    logic [31:0] ux, uy;
    ux = x;
    uy = y;
    return ux * uy;
`endif
  endfunction
  function automatic logic [15:0] pick(input vec_t v);
`ifdef VEDIC_SIGNED_EN
    return v.ss;
`else
    return v.su;
`endif
  endfunction
  task automatic run1(input string nm, input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
    int n;
    chk({nm, " in_ready"}, ir8, 1'b1);
    a8 = x;
    b8 = y;
    iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    n = 1;
    while (!ov8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, LAT8);
    chk({nm, " s"}, s8, e);
  endtask
  initial begin
    int n, cnt, first, last;
    logic pend;
    rst = 1'b1;
    iv8 = 0; a8 = 0; b8 = 0; or8 = 1;
    iv4 = 0; a4 = 0; b4 = 0; or4 = 1;
    iv16 = 0; a16 = 0; b16 = 0; or16 = 1;
    tbl[0]  = '{8'd255, 8'd255, 16'd65025, 16'd1};
    tbl[1]  = '{8'd0,   8'd200, 16'd0,     16'd0};
    tbl[2]  = '{8'd3,   8'd7,   16'd21,    16'd21};
    tbl[3]  = '{8'd12,  8'd12,  16'd144,   16'd144};
    tbl[4]  = '{8'd100, 8'd2,   16'd200,   16'd200};
    tbl[5]  = '{8'd128, 8'd128, 16'd16384, 16'd16384};
    tbl[6]  = '{8'd255, 8'd127, 16'd32385, 16'hFF81};
    tbl[7]  = '{8'd127, 8'd127, 16'd16129, 16'd16129};
    tbl[8]  = '{8'd1,   8'd255, 16'd255,   16'hFFFF};
    tbl[9]  = '{8'd170, 8'd85,  16'd14450, 16'hE372};
    tbl[10] = '{8'd16,  8'd16,  16'd256,   16'd256};
    tbl[11] = '{8'd200, 8'd3,   16'd600,   16'hFF58};
    bp_exp[0] = 16'd21;
    bp_exp[1] = 16'd144;
    bp_exp[2] = 16'd200;
    a8 = 8'hA5; b8 = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", ov8, 1'b0);
    chk("reset s", s8, 16'd0);
    chk("reset in_ready", ir8, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle s", s8, 16'd0);
    for (int i = 0; i < 12; i++) run1($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, pick(tbl[i]));
    repeat (LAT8 + 1) @(negedge clk);
    or8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a8 = tbl[2+i].a;
      b8 = tbl[2+i].b;
      iv8 = 1'b1;
      @(negedge clk);
    end
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp out_valid", ov8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp stall in_ready", ir8, 1'b0);
      chk("bp stall out_valid", ov8, 1'b1);
      chk("bp stall s", s8, 16'd21);
      @(negedge clk);
    end
    or8 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (ov8) begin
        if (cnt < 3) chk($sformatf("bp out%0d", cnt), s8, bp_exp[cnt]);
        cnt++;
      end
      @(negedge clk);
    end
    chk("bp out count", cnt, 3);
    a8 = 8'd5; b8 = 8'd5; iv8 = 1'b1;
    @(negedge clk);
    a8 = 8'd6; b8 = 8'd6;
    @(negedge clk);
    iv8 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst out_valid", ov8, 1'b0);
    chk("midrst s", s8, 16'd0);
    chk("midrst in_ready", ir8, 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (ov8) cnt++;
      @(negedge clk);
    end
    chk("midrst no stale", cnt, 0);
    run1("cold", 8'd9, 8'd9, 16'd81);
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 270; c++) begin
      if (c < 256) begin
        a4 = c[7:4];
        b4 = c[3:0];
        iv4 = 1'b1;
      end else iv4 = 1'b0;
      #1;
      if (iv4 && ir4) q4.push_back(m4(a4, b4));
      if (ov4) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
        if (q4.size() > 0) chk("w4 s", s4, q4.pop_front());
        else chk("w4 extra", q4.size(), 1);
      end
      @(negedge clk);
    end
    chk("w4 count", cnt, 256);
    chk("w4 gapless", last - first, 255);
    pend = 1'b0;
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pend) begin
        iv16 = (c < 360) ? 1'($urandom_range(0, 1)) : 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
      end
      or16 = (c < 360) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (ov16 && or16) begin
        cnt++;
        if (q16.size() > 0) chk("w16 s", s16, q16.pop_front());
        else chk("w16 extra", q16.size(), 1);
      end
      if (iv16 && ir16) begin
        q16.push_back(m16(a16, b16));
        pend = 1'b0;
      end else pend = iv16;
      @(negedge clk);
    end
    chk("w16 drained", q16.size(), 0);
    chk("w16 some output", cnt > 50, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
